// File: rtl/alu_muldiv_seq_pkg.sv
// alu_pkg: opcodes, FSM states and helpers shared by the sequential ALU
package alu_pkg;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_MFHI = 4'b1010;
    localparam logic [3:0] OP_MFLO = 4'b1011;
    localparam logic [3:0] OP_MTHI = 4'b1100;
    localparam logic [3:0] OP_MTLO = 4'b1101;

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op == OP_MULT || op == OP_DIV;
    endfunction
endpackage

// File: rtl/alu_muldiv_seq_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   sum, shf, dif;

    always_comb begin
        sum = {1'b0, hi} + {1'b0, d};
        shf = {hi, lo[WIDTH-1]};
        dif = shf - {1'b0, d};
    end

    // mode 0: hi accumulates partial product, lo shifts out the multiplier
    // mode 1: hi is the partial remainder, lo shifts the dividend out and quotient bits in
    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            d  <= '0;
        end else if (load) begin
            hi <= '0;
            lo <= x;
            d  <= y;
        end else if (step) begin
            if (!mode)
                {hi, lo} <= lo[0] ? {sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
            else begin
                hi <= dif[WIDTH] ? shf[WIDTH-1:0] : dif[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], ~dif[WIDTH]};
            end
        end
    end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: registered ALU with iterative MULT/DIV and HI/LO behind a start/busy/done handshake
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic             unsig,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] aluout,
    output logic             compout,
    output logic             overflow,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               req_v, req_u;
    logic [3:0]         req_op;
    logic [WIDTH-1:0]   req_a, req_b, hi_q, lo_q, it_hi, it_lo;
    logic [WIDTH-1:0]   mag_a, mag_b, sum, dif, res, quo, rem;
    logic [2*WIDTH-1:0] prod, fix;
    logic               accept, lt, ovf, neg_a, neg_b, dz, is_div, div_ovf, it_load;

    // a captured MULT/DIV not yet in ITER also blocks new requests
    always_comb begin
        accept  = start && !busy && !(req_v && is_muldiv(req_op));
        is_div  = req_op == OP_DIV;
        neg_a   = !req_u && req_a[WIDTH-1];
        neg_b   = !req_u && req_b[WIDTH-1];
        mag_a   = neg_a ? -req_a : req_a;
        mag_b   = neg_b ? -req_b : req_b;
        dz      = req_b == '0;
        it_load = state == IDLE && req_v && is_muldiv(req_op) && !(is_div && dz);
        lt      = req_u ? (req_a < req_b) : ($signed(req_a) < $signed(req_b));
        sum     = req_a + req_b;
        dif     = req_a - req_b;
        ovf     = !req_u && (req_op == OP_ADD ?
                  (req_a[WIDTH-1] == req_b[WIDTH-1] && sum[WIDTH-1] != req_a[WIDTH-1]) :
                  (req_op == OP_SUB && req_a[WIDTH-1] != req_b[WIDTH-1] && dif[WIDTH-1] != req_a[WIDTH-1]));
        prod    = (neg_a ^ neg_b) ? -{it_hi, it_lo} : {it_hi, it_lo};
        quo     = (neg_a ^ neg_b) ? -it_lo : it_lo;
        rem     = neg_a ? -it_hi : it_hi;
        fix     = !is_div ? prod : dz ? {req_a, {WIDTH{1'b1}}} : {rem, quo};
        div_ovf = is_div && !req_u && req_a == MIN && req_b == '1;
        res     = '0;
        case (req_op)
            OP_AND:  res = req_a & req_b;
            OP_OR:   res = req_a | req_b;
            OP_ADD:  res = sum;
            OP_NOR:  res = ~(req_a | req_b);
            OP_XOR:  res = req_a ^ req_b;
            OP_SUB:  res = dif;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt};
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            OP_MTHI: res = req_a;
            OP_MTLO: res = req_a;
            default: res = '0;
        endcase
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clock(clock),
        .reset(reset),
        .load (it_load),
        .step (state == ITER),
        .mode (is_div),
        .x    (mag_a),
        .y    (mag_b),
        .hi   (it_hi),
        .lo   (it_lo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            req_v    <= 1'b0;
            req_u    <= 1'b0;
            req_op   <= OP_AND;
            req_a    <= '0;
            req_b    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aluout   <= '0;
            compout  <= 1'b0;
            overflow <= 1'b0;
            divzero  <= 1'b0;
        end else begin
            done  <= 1'b0;
            req_v <= accept;
            if (accept) begin
                req_op <= op;
                req_u  <= unsig;
                req_a  <= a;
                req_b  <= b;
            end
            case (state)
                IDLE: begin
                    if (req_v && is_muldiv(req_op)) begin
                        busy  <= 1'b1;
                        state <= (is_div && dz) ? FIX : ITER;
                        cnt   <= CW'(WIDTH - 1);
                    end else if (req_v) begin
                        done     <= 1'b1;
                        aluout   <= res;
                        compout  <= lt;
                        overflow <= ovf;
                        divzero  <= 1'b0;
                        if (req_op == OP_MTHI) hi_q <= req_a;
                        if (req_op == OP_MTLO) lo_q <= req_a;
                    end
                end
                ITER: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    done         <= 1'b1;
                    {hi_q, lo_q} <= fix;
                    aluout       <= fix[WIDTH-1:0];
                    compout      <= lt;
                    overflow     <= div_ovf;
                    divzero      <= is_div && dz;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
